// File: rtl/cpu_debug_scan_master_pkg.sv
// Shared definitions for the debug scan master: FSM state codes, default widths
// and the debug instruction-register codes understood by the target.
package cpu_debug_scan_master_pkg;

    localparam int DR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    // Kept as plain constants so older tools and waveform scripts see stable codes.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_UIR  = 3'd1;
    localparam state_t ST_CDR  = 3'd2;
    localparam state_t ST_SDR  = 3'd3;
    localparam state_t ST_UDR  = 3'd4;
    localparam state_t ST_RSP  = 3'd5;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } debug_ir_e;

    // Width of a down-counter that must hold values 0..len-1.
    function automatic int cnt_width(input int len);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/cpu_debug_scan_master_if.sv
// Command/response handshake plus the virtual-JTAG pins of the scan master.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface cpu_debug_scan_master_if
    import cpu_debug_scan_master_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] ir_in;
    logic                jtag_state_rti;
    logic                virtual_state_uir;
    logic                virtual_state_cdr;
    logic                virtual_state_sdr;
    logic                virtual_state_udr;
    logic                tdi;
    logic                tdo;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
        output cmd_ready, rsp_valid, rsp_dr, ir_in, jtag_state_rti,
        output virtual_state_uir, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
        output tdi
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
        input  cmd_ready, rsp_valid, rsp_dr, ir_in, jtag_state_rti,
        input  virtual_state_uir, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
        input  tdi
    );

endinterface

// File: rtl/cpu_debug_scan_master_scan_shift_reg.sv
// Parallel-load right shifter: bit 0 leaves on serial_out, serial_in enters at the MSB.
module scan_shift_reg #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data,
    output logic             serial_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {serial_in, data[WIDTH-1:1]};
        end
    end

    assign serial_out = data[0];

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Debug scan master: takes one IR/DR command, walks UIR-CDR-SDR-UDR on the virtual
// JTAG strobes while shifting the DR through the target, then holds the captured DR as a response.
module cpu_debug_scan_master
    import cpu_debug_scan_master_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_debug_scan_master_if.master bus,
    output state_t                  dbg_state
);

    localparam int CNT_W = cnt_width(DR_WIDTH);

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] shift_data;
    logic                shift_out;
    logic                accept;
    logic                shift_en;

    assign accept   = (state == ST_IDLE) && bus.cmd_valid;
    assign shift_en = (state == ST_SDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            ir_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ir_q  <= bus.cmd_ir;
                        state <= ST_UIR;
                    end
                end
                ST_UIR: state <= ST_CDR;
                ST_CDR: begin
                    bit_cnt <= CNT_W'(DR_WIDTH - 1);
                    state   <= ST_SDR;
                end
                ST_SDR: begin
                    // The cycle that sees a zero count is the last of the DR_WIDTH shifts.
                    if (bit_cnt == '0) begin
                        state <= ST_UDR;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                ST_UDR: state <= ST_RSP;
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    scan_shift_reg #(
        .WIDTH (DR_WIDTH)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  (bus.cmd_dr),
        .shift_en   (shift_en),
        .serial_in  (bus.tdo),
        .data       (shift_data),
        .serial_out (shift_out)
    );

    // Strobes are decoded straight from the state so at most one can ever be high.
    assign bus.cmd_ready         = (state == ST_IDLE);
    assign bus.jtag_state_rti    = (state == ST_IDLE);
    assign bus.virtual_state_uir = (state == ST_UIR);
    assign bus.virtual_state_cdr = (state == ST_CDR);
    assign bus.virtual_state_sdr = shift_en;
    assign bus.virtual_state_udr = (state == ST_UDR);
    assign bus.tdi               = shift_en & shift_out;
    assign bus.ir_in             = ir_q;
    assign bus.rsp_valid         = (state == ST_RSP);
    assign bus.rsp_dr            = (state == ST_RSP) ? shift_data : '0;
    assign dbg_state             = state;

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Self-checking bench for cpu_debug_scan_master: a cycle-offset reference model checked
// every cycle, directed scenarios with literal expectations, and a long random run.
module tb_cpu_debug_scan_master;
  import cpu_debug_scan_master_pkg::*;

  localparam int DR = 38;
  localparam int IR = 2;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  cpu_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus ();

  cpu_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / tdo source ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tdo_mode = 0;  // 0 fixed value, 1 loop tdi back, 2 random
  logic tdo_val = 1'b0;
  logic tdo_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    tdo_rand = 1'($urandom_range(0, 1));
  end
  assign bus.tdo = (tdo_mode == 1) ? bus.tdi : ((tdo_mode == 2) ? tdo_rand : tdo_val);

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [DR-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model (cycles since accept) ----------------
  bit            m_busy = 1'b0;
  int            k = 0;
  logic [IR-1:0] m_ir = '0;
  logic [DR-1:0] m_dr = '0;
  logic [DR-1:0] m_cap = '0;

  // statistics observed from the DUT, reset at every accepted command
  int n_acc = 0, n_rsp = 0;
  int acc_cyc = 0, prev_acc_cyc = 0, hs_cyc = 0;
  int uir_cnt = 0, cdr_cnt = 0, sdr_cnt = 0, udr_cnt = 0, tdi_ones = 0;
  int uir_off = -1, cdr_off = -1, udr_off = -1, first_rsp_off = -1;
  logic [DR-1:0] last_rsp = '0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit   e_sdr, e_rsp, e_tdi;
      int   off;
      logic [DR-1:0] popped;
      e_sdr = m_busy && (k >= 3) && (k <= DR + 2);
      e_rsp = m_busy && (k >= DR + 4);
      e_tdi = 1'b0;
      if (e_sdr) e_tdi = m_dr[k-3];

      chk("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy));
      chk("rti", 64'(bus.jtag_state_rti), 64'(!m_busy));
      chk("uir", 64'(bus.virtual_state_uir), 64'(m_busy && k == 1));
      chk("cdr", 64'(bus.virtual_state_cdr), 64'(m_busy && k == 2));
      chk("sdr", 64'(bus.virtual_state_sdr), 64'(e_sdr));
      chk("udr", 64'(bus.virtual_state_udr), 64'(m_busy && k == DR + 3));
      chk("tdi", 64'(bus.tdi), 64'(e_tdi));
      chk("ir_in", 64'(bus.ir_in), 64'(m_ir));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
      chk("rsp_dr", 64'(bus.rsp_dr), e_rsp ? 64'(m_cap) : 64'd0);
      chk("one_strobe", 64'(int'(bus.virtual_state_uir) + int'(bus.virtual_state_cdr) +
          int'(bus.virtual_state_sdr) + int'(bus.virtual_state_udr) <= 1), 64'd1);

      off = cyc - acc_cyc;
      if (bus.virtual_state_uir) begin uir_cnt++; uir_off = off; end
      if (bus.virtual_state_cdr) begin cdr_cnt++; cdr_off = off; end
      if (bus.virtual_state_sdr) begin sdr_cnt++; if (bus.tdi) tdi_ones++; end
      if (bus.virtual_state_udr) begin udr_cnt++; udr_off = off; end
      if (bus.rsp_valid && first_rsp_off < 0) first_rsp_off = off;

      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
        hs_cyc   = cyc;
        last_rsp = bus.rsp_dr;
        n_rsp++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_dr), 64'hDEAD);
        end else begin
          popped = exp_q.pop_front();
          chk("rsp_scoreboard", 64'(bus.rsp_dr), 64'(popped));
        end
      end
      if (!reset && bus.cmd_valid && bus.cmd_ready) begin
        prev_acc_cyc = acc_cyc;
        acc_cyc = cyc;
        n_acc++;
        uir_cnt = 0; cdr_cnt = 0; sdr_cnt = 0; udr_cnt = 0; tdi_ones = 0;
        uir_off = -1; cdr_off = -1; udr_off = -1; first_rsp_off = -1;
      end

      // advance the model to the state after the coming rising edge
      if (reset) begin
        m_busy = 1'b0; k = 0; m_ir = '0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (bus.cmd_valid) begin
          m_busy = 1'b1; k = 1; m_ir = bus.cmd_ir; m_dr = bus.cmd_dr; m_cap = '0;
        end
      end else begin
        if (e_sdr) m_cap[k-3] = bus.tdo;
        if (e_rsp) begin
          if (bus.rsp_ready) begin m_busy = 1'b0; k = 0; end
        end else begin
          k++;
          if (k == DR + 4) exp_q.push_back(m_cap);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [IR-1:0] ir, input logic [DR-1:0] dr);
    int a0;
    bit ok;
    a0 = n_acc;
    ok = 1'b0;
    bus.cmd_ir = ir;
    bus.cmd_dr = dr;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (n_acc != a0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_rsp != n0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [DR-1:0] rand_dr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DR-1:0];
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0, a0, c1, c2, last_acc, sent, target;
    bit ok;
    reset = 1'b1;
    bus.cmd_valid = 1'b1;  // reset must win over a pending command
    bus.cmd_ir = 2'd3;
    bus.cmd_dr = '1;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_dr", 64'(bus.rsp_dr), 64'd0);
    chk("reset_ir_in", 64'(bus.ir_in), 64'd0);
    chk("reset_rti", 64'(bus.jtag_state_rti), 64'd1);
    @(posedge clk); #1;

    // loopback scan, BREAK register
    tdo_mode = 1;
    bus.rsp_ready = 1'b1;
    n0 = n_rsp;
    send_cmd(IR_BREAK, 38'h15_5555_5555);
    wait_rsp(n0);
    chk("lb_uir_cycle", 64'(uir_off), 64'd1);
    chk("lb_cdr_cycle", 64'(cdr_off), 64'd2);
    chk("lb_sdr_count", 64'(sdr_cnt), 64'd38);
    chk("lb_udr_cycle", 64'(udr_off), 64'd41);
    chk("lb_rsp_cycle", 64'(first_rsp_off), 64'd42);
    chk("lb_rsp_dr", 64'(last_rsp), 64'h15_5555_5555);
    chk("lb_uir_count", 64'(uir_cnt), 64'd1);

    // tdo stuck at 1 with an all-zero DR
    tdo_mode = 0;
    tdo_val = 1'b1;
    n0 = n_rsp;
    send_cmd(IR_TRACEMEM, '0);
    wait_rsp(n0);
    chk("ones_rsp_dr", 64'(last_rsp), 64'h3F_FFFF_FFFF);
    chk("ones_tdi_zero", 64'(tdi_ones), 64'd0);

    // back-pressured response and a command offered while busy
    tdo_mode = 2;
    bus.rsp_ready = 1'b0;
    n0 = n_rsp;
    send_cmd(IR_TRACECTRL, rand_dr());
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (first_rsp_off >= 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("bp_rsp_timeout", 64'd0, 64'd1);
    bus.cmd_ir = IR_TRACEMEM;
    bus.cmd_dr = rand_dr();
    bus.cmd_valid = 1'b1;
    a0 = n_acc;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_cmd_ignored", 64'(n_acc - a0), 64'd0);
    chk("bp_no_handshake", 64'(n_rsp - n0), 64'd0);
    bus.rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (n_acc != a0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_accept_timeout", 64'd0, 64'd1);
    bus.cmd_valid = 1'b0;
    chk("bp_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
    n0 = n_rsp;
    wait_rsp(n0);

    // reset during SDR cycle 20
    bus.rsp_ready = 1'b1;
    n0 = n_rsp;
    send_cmd(IR_OCIMEM, rand_dr());
    repeat (22) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_ir_in", 64'(bus.ir_in), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_sdr_count", 64'(sdr_cnt), 64'd21);
    chk("abort_no_udr", 64'(udr_cnt), 64'd0);
    chk("abort_no_rsp", 64'(n_rsp - n0), 64'd0);

    // back-to-back commands with cmd_valid held
    bus.cmd_ir = IR_OCIMEM;
    bus.cmd_dr = rand_dr();
    bus.cmd_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 20 && n_acc == a0; i++) begin @(posedge clk); #1; end
    c1 = acc_cyc;
    bus.cmd_ir = IR_TRACECTRL;
    bus.cmd_dr = rand_dr();
    a0 = n_acc;
    for (int i = 0; i < 100 && n_acc == a0; i++) begin @(posedge clk); #1; end
    c2 = acc_cyc;
    bus.cmd_valid = 1'b0;
    chk("b2b_gap", 64'(c2 - c1), 64'd43);
    n0 = n_rsp;
    wait_rsp(n0);
    chk("b2b_uir", 64'(uir_cnt), 64'd1);
    chk("b2b_cdr", 64'(cdr_cnt), 64'd1);
    chk("b2b_sdr", 64'(sdr_cnt), 64'd38);
    chk("b2b_udr", 64'(udr_cnt), 64'd1);

    // random traffic: 500 commands, random tdo and rsp_ready
    target = n_rsp + 500;
    sent = 0;
    last_acc = n_acc;
    for (int c = 0; c < 60000 && n_rsp < target; c++) begin
      @(posedge clk); #1;
      if (bus.cmd_valid && n_acc != last_acc) begin
        sent++;
        bus.cmd_valid = 1'b0;
      end
      last_acc = n_acc;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.cmd_valid && sent < 500 && $urandom_range(0, 2) == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_ir = IR'($urandom_range(0, 3));
        bus.cmd_dr = rand_dr();
      end
    end
    bus.cmd_valid = 1'b0;
    chk("random_responses", 64'(n_rsp), 64'(target));
    chk("random_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
